ram_port_ctrl: RTL
==================

RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  DATA_WIDTH  8    data word width, matches the RAM word width
  ADDR_WIDTH  8    RAM address width
  RAM_DEPTH   1<<ADDR_WIDTH    number of words swept by a clear
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk         in     1           single clock; all state updates on rising edge
  reset_n     in     1           asynchronous, active-low reset
  req_valid   in     1           request present
  req_ready   out    1           controller can accept a request
  req_we      in     1           1 = write request, 0 = read request
  req_addr    in     ADDR_WIDTH  request address
  req_wdata   in     DATA_WIDTH  write data
  rsp_valid   out    1           one-cycle pulse: rsp_rdata is valid
  rsp_rdata   out    DATA_WIDTH  read data, held until the next read
  clear_start in     1           request a sweep that writes zero to every RAM word
  clear_done  out    1           one-cycle pulse when the sweep completes
  busy        out    1           high in any state other than IDLE
  ram_address out    ADDR_WIDTH  to RAM port address
  ram_data    inout  DATA_WIDTH  to RAM bidirectional data port
  ram_cs      out    1           RAM chip select
  ram_we      out    1           RAM write enable
  ram_oe      out    1           RAM output enable
REQ-003 One clock (clk) SHALL be used; reset_n SHALL be asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, WRITE, READ, CAPTURE and CLEAR.
REQ-005 req_ready SHALL equal (state==IDLE); a request SHALL be accepted on a rising edge with req_valid&&req_ready.
REQ-006 On acceptance, req_addr and req_wdata SHALL be latched into registers; next state SHALL be WRITE if req_we=1, otherwise READ.
REQ-007 In IDLE with clear_start=1, clear_start SHALL win over req_valid, and the request SHALL stay pending (not accepted).
REQ-008 In IDLE, clear_start=1 SHALL load the address counter with 0 and go to CLEAR.
REQ-009 In WRITE, outputs SHALL be: ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with the latched wdata, ram_address = latched address. Next state SHALL be IDLE.
REQ-010 In READ, outputs SHALL be ram_cs=1, ram_we=0, ram_oe=1, ram_address = latched address. Next state SHALL be CAPTURE.
REQ-011 In CAPTURE, the READ outputs SHALL be held. At the closing edge, rsp_rdata SHALL load ram_data, rsp_valid SHALL be 1 for exactly the following cycle, and next state SHALL be IDLE.
REQ-012 Read latency SHALL be: accept at edge N, rsp_valid high in the cycle after edge N+2.
REQ-013 Throughput SHALL be: write 2 cycles per transaction, read 3 cycles per transaction.
REQ-014 In CLEAR, outputs SHALL be ram_cs=1, ram_we=1, ram_oe=0, ram_data driven with all zeros, ram_address = counter.
REQ-015 In CLEAR, the counter SHALL increment by 1 per cycle.
REQ-016 In CLEAR with counter==RAM_DEPTH-1, the FSM SHALL go to IDLE, the counter SHALL wrap to 0, and clear_done SHALL be high for the next cycle. A sweep SHALL take exactly RAM_DEPTH cycles.
REQ-017 clear_start SHALL be ignored outside IDLE; a level held high in IDLE SHALL start a new sweep.
REQ-018 ram_data SHALL be driven only when ram_we=1; otherwise it SHALL be high-impedance on all bits.
REQ-019 In IDLE, ram_cs, ram_we and ram_oe SHALL be 0, and ram_address SHALL hold its last value.
REQ-020 busy SHALL be 1 in WRITE, READ, CAPTURE and CLEAR.

Reset
REQ-021 While reset_n=0, regardless of clk, the block SHALL force: state=IDLE, counter=0, ram_address=0, ram_cs=ram_we=ram_oe=0, ram_data high-impedance, rsp_valid=0, rsp_rdata=0, clear_done=0, busy=0.
REQ-022 Reset asserted mid-transaction or mid-sweep SHALL abort it with no rsp_valid and no clear_done; after release, req_ready SHALL be 1 in the first cycle.

Verification
REQ-023 Write then read: write addr 0x10 data 0xA5, then read 0x10 -> WRITE lasts 1 cycle with bus=0xA5; rsp_valid pulses exactly 3 cycles after read acceptance with rsp_rdata=0xA5.
REQ-024 Back-to-back: req_valid held high with writes to 0x00..0x03 (data 0x11..0x44), then reads of 0x00..0x03 -> accepts every 2 cycles for writes and every 3 cycles for reads; responses return 0x11,0x22,0x33,0x44 in order.
REQ-025 Clear: preload 0xFF at 0x00 and 0xFF, pulse clear_start -> busy for 256 cycles, ram_address 0..255, bus 0x00; clear_done pulses once; reads of 0x00 and 0xFF return 0x00.
REQ-026 Priority: clear_start and a read request asserted in the same IDLE cycle -> CLEAR entered, req_ready low throughout the sweep; the read is accepted in the cycle after clear_done.
REQ-027 Async reset: reset_n pulled low mid-cycle in CAPTURE, and separately at counter=0x40 in CLEAR -> immediate IDLE outputs, no rsp_valid or clear_done, bus Z.
REQ-028 Bus hygiene: on every cycle with ram_we=0, ram_data is all-Z from the controller; a RAM model driving 0x5A during CAPTURE is captured as 0x5A.

Source files
------------

// File: rtl/ram_port_ctrl.sv
// Single-port asynchronous SRAM controller: one request at a time (write or read)
// plus a zero-fill sweep of the whole RAM, sharing one bidirectional data bus.
`timescale 1ns/1ps
module ram_port_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear_start,
  output logic                  clear_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    clear_done_q, clear_done_d;
  logic [DATA_WIDTH-1:0]   bus_drive;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      last_addr_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_addr_q  <= last_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_addr_d  = last_addr_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    clear_done_d = 1'b0;
    ram_cs       = 1'b0;
    ram_we       = 1'b0;
    ram_oe       = 1'b0;
    ram_address  = last_addr_q;
    bus_drive    = '0;

    case (state_q)
      S_IDLE: begin
        // A sweep request wins; any pending request simply waits for IDLE again.
        if (clear_start) begin
          cnt_d   = '0;
          state_d = S_CLEAR;
        end else if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        ram_address = addr_q;
        bus_drive   = wdata_q;
        last_addr_d = addr_q;
        state_d     = S_IDLE;
      end
      S_READ: begin
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_address = addr_q;
        last_addr_d = addr_q;
        state_d     = S_CAPTURE;
      end
      S_CAPTURE: begin
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_address = addr_q;
        last_addr_d = addr_q;
        rsp_rdata_d = ram_data;
        rsp_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      S_CLEAR: begin
        ram_cs      = 1'b1;
        ram_we      = 1'b1;
        ram_address = cnt_q;
        last_addr_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          clear_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ram_data   = ram_we ? bus_drive : {DATA_WIDTH{1'bz}};
  assign req_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign clear_done = clear_done_q;

endmodule
